// File: rtl/axis_ddr_adc_capture.sv
// Purpose: de-interleave a DDR ADC bus into channel A/B, format each channel, and stream pairs on AXIS inside an armed/triggered/length-counted window.
// Latency: A at rising edge k (B at the next falling edge) reaches the format register after edge k+2 and m_axis_tdata after edge k+3.
// Backpressure: single output register; a pair offered while a beat is stalled is dropped and counted, never queued.
module axis_ddr_adc_capture #(
    parameter int ADC_DATA_WIDTH   = 14,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [ADC_DATA_WIDTH-1:0]   adc_data,
    input  logic [CNTR_WIDTH-1:0]       cfg_length,
    input  logic                        cfg_swap,
    input  logic                        cfg_offset_bin,
    input  logic                        cfg_continuous,
    input  logic                        arm,
    input  logic                        stop,
    input  logic                        trg_flag,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tlast,
    output logic                        sts_busy,
    output logic                        sts_overflow,
    output logic [CNTR_WIDTH-1:0]       sts_drops
);

    localparam int HALF = AXIS_TDATA_WIDTH / 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // DDR capture registers; behavioural equivalent of IDDRE1 SAME_EDGE_PIPELINED
    logic [ADC_DATA_WIDTH-1:0] rise_q;
    logic [ADC_DATA_WIDTH-1:0] fall_q;
    logic [ADC_DATA_WIDTH-1:0] pair_a;
    logic [ADC_DATA_WIDTH-1:0] pair_b;

    logic [AXIS_TDATA_WIDTH-1:0] fmt_q;
    logic [CNTR_WIDTH-1:0]       cnt;

    logic arm_ok;
    logic offer;
    logic load;
    logic drop;
    logic last_beat;

    // Offset-binary correction (MSB flip) followed by sign extension to half the bus
    function automatic logic [HALF-1:0] fmt_ch(input logic [ADC_DATA_WIDTH-1:0] s,
                                               input logic ob);
        logic [ADC_DATA_WIDTH-1:0] t;
        t = s;
        t[ADC_DATA_WIDTH-1] = t[ADC_DATA_WIDTH-1] ^ ob;
        return HALF'($signed(t));
    endfunction

    // Rising-edge sample of channel A
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rise_q <= '0;
        else          rise_q <= adc_data;
    end

    // Falling-edge sample of channel B
    always_ff @(negedge aclk or negedge aresetn) begin
        if (!aresetn) fall_q <= '0;
        else          fall_q <= adc_data;
    end

    // Re-time both halves onto the same rising edge so the pair moves together
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pair_a <= '0;
            pair_b <= '0;
        end else begin
            pair_a <= rise_q;
            pair_b <= fall_q;
        end
    end

    // Format register: per-channel conversion and lane ordering
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            fmt_q <= '0;
        end else if (cfg_swap) begin
            fmt_q <= {fmt_ch(pair_a, cfg_offset_bin), fmt_ch(pair_b, cfg_offset_bin)};
        end else begin
            fmt_q <= {fmt_ch(pair_b, cfg_offset_bin), fmt_ch(pair_a, cfg_offset_bin)};
        end
    end

    // FSM state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // FSM next-state logic; stop wins over arm and trigger
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (arm_ok) state_nxt = S_ARMED;
            S_ARMED: begin
                if (stop)          state_nxt = S_IDLE;
                else if (trg_flag) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (stop)                   state_nxt = S_IDLE;
                else if (load && last_beat) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: arm acceptance, per-cycle load/drop decision, end-of-window detect
    always_comb begin
        arm_ok    = (state == S_IDLE) && arm && !stop &&
                    ((cfg_length != '0) || cfg_continuous);
        offer     = (state == S_RUN) && !stop;
        load      = offer && (!m_axis_tvalid || m_axis_tready);
        drop      = offer && m_axis_tvalid && !m_axis_tready;
        last_beat = !cfg_continuous && (cnt == CNTR_WIDTH'(1));
    end

    // Beat down-counter, latched on an accepted arm
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)   cnt <= '0;
        else if (arm_ok) cnt <= cfg_length;
        else if (load)   cnt <= cnt - CNTR_WIDTH'(1);
    end

    // AXIS output register; data held while stalled, valid drops on handshake unless refilled
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= fmt_q;
            m_axis_tlast  <= last_beat;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Drop accounting: saturating counter and sticky flag, both cleared by an accepted arm
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sts_drops    <= '0;
            sts_overflow <= 1'b0;
        end else if (arm_ok) begin
            sts_drops    <= '0;
            sts_overflow <= 1'b0;
        end else if (drop) begin
            sts_overflow <= 1'b1;
            if (sts_drops != '1) sts_drops <= sts_drops + CNTR_WIDTH'(1);
        end
    end

    // Registered busy flag tracking the next state
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) sts_busy <= 1'b0;
        else          sts_busy <= (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_axis_ddr_adc_capture.sv
// Directed bench for axis_ddr_adc_capture: format, windowed capture, back-pressure, abort, edge cases.
// Inputs change shortly after clock edges; outputs and handshakes are sampled on the falling edge.
// Beats are collected by a monitor queue and compared against hand-derived values.
module tb_axis_ddr_adc_capture;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [13:0] adc_data = '0;
    logic [31:0] cfg_length = '0;
    logic        cfg_swap = 1'b0;
    logic        cfg_offset_bin = 1'b0;
    logic        cfg_continuous = 1'b0;
    logic        arm = 1'b0;
    logic        stop = 1'b0;
    logic        trg_flag = 1'b0;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        sts_busy;
    logic        sts_overflow;
    logic [31:0] sts_drops;

    int checks = 0;
    int errors = 0;

    axis_ddr_adc_capture #(
        .ADC_DATA_WIDTH(14),
        .AXIS_TDATA_WIDTH(32),
        .CNTR_WIDTH(32)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .adc_data(adc_data),
        .cfg_length(cfg_length),
        .cfg_swap(cfg_swap),
        .cfg_offset_bin(cfg_offset_bin),
        .cfg_continuous(cfg_continuous),
        .arm(arm),
        .stop(stop),
        .trg_flag(trg_flag),
        .m_axis_tready(m_axis_tready),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast),
        .sts_busy(sts_busy),
        .sts_overflow(sts_overflow),
        .sts_drops(sts_drops)
    );

    always #5 aclk = ~aclk;

    // DDR source: A is stable around the rising edge, B around the falling edge
    logic [13:0] a_cur = 14'h0000;
    logic [13:0] b_cur = 14'h0000;
    bit          ramp = 1'b0;

    initial begin
        forever begin
            @(negedge aclk);
            #1 adc_data = a_cur;
            @(posedge aclk);
            #1 adc_data = b_cur;
            if (ramp) begin
                a_cur = a_cur + 14'd1;
                b_cur = b_cur + 14'd1;
            end
        end
    end

    // Beat monitor
    int          cyc = 0;
    logic [31:0] beat_q[$];
    bit          last_q[$];
    bit          busy_q[$];
    int          cyc_q[$];

    always @(posedge aclk) cyc = cyc + 1;

    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            beat_q.push_back(m_axis_tdata);
            last_q.push_back(m_axis_tlast);
            busy_q.push_back(sts_busy);
            cyc_q.push_back(cyc);
        end
    end

    task automatic clear_q();
        beat_q.delete();
        last_q.delete();
        busy_q.delete();
        cyc_q.delete();
    endtask

    task automatic pulse_arm();
        @(posedge aclk); #2 arm = 1'b1;
        @(posedge aclk); #2 arm = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge aclk); #2 stop = 1'b1;
        @(posedge aclk); #2 stop = 1'b0;
    endtask

    task automatic pulse_trg();
        @(posedge aclk); #2 trg_flag = 1'b1;
        @(posedge aclk); #2 trg_flag = 1'b0;
    endtask

    task automatic arm_trig();
        pulse_arm();
        trg_flag = 1'b1;
        @(posedge aclk); #2 trg_flag = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got %h want 0", m_axis_tdata); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", m_axis_tlast); end
        checks++; if (sts_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", sts_busy); end
        checks++; if (sts_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", sts_overflow); end
        checks++; if (sts_drops !== 32'h0) begin errors++; $display("FAIL reset_drops got %0d want 0", sts_drops); end
        @(posedge aclk); #2 aresetn = 1'b1;
    endtask

    task automatic test_format();
        logic [31:0] exp_tab [4];
        exp_tab[0] = 32'h1FFF_E001;  // binary, {B,A}
        exp_tab[1] = 32'hFFFF_0001;  // offset binary, {B,A}
        exp_tab[2] = 32'hE001_1FFF;  // binary, {A,B}
        exp_tab[3] = 32'h0001_FFFF;  // offset binary, {A,B}
        ramp  = 1'b0;
        a_cur = 14'h2001;
        b_cur = 14'h1FFF;
        cfg_length = 32'd1;
        cfg_continuous = 1'b0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cfg_offset_bin = i[0];
            cfg_swap       = i[1];
            repeat (5) @(posedge aclk);
            clear_q();
            arm_trig();
            repeat (6) @(posedge aclk);
            @(negedge aclk);
            checks++;
            if (beat_q.size() != 1) begin
                errors++; $display("FAIL fmt_count[%0d] got %0d want 1", i, beat_q.size());
            end else begin
                checks++; if (beat_q[0] !== exp_tab[i]) begin errors++; $display("FAIL fmt_data[%0d] got %h want %h", i, beat_q[0], exp_tab[i]); end
                checks++; if (last_q[0] !== 1'b1) begin errors++; $display("FAIL fmt_last[%0d] got %b want 1", i, last_q[0]); end
            end
            checks++; if (sts_busy !== 1'b0) begin errors++; $display("FAIL fmt_busy_end[%0d] got %b want 0", i, sts_busy); end
        end
        cfg_offset_bin = 1'b0;
        cfg_swap = 1'b0;
    endtask

    task automatic test_window();
        a_cur = 14'h0010;
        b_cur = 14'h0110;
        ramp  = 1'b1;
        cfg_length = 32'd8;
        m_axis_tready = 1'b1;
        repeat (4) @(posedge aclk);
        clear_q();
        pulse_arm();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        checks++; if (sts_busy !== 1'b1) begin errors++; $display("FAIL win_busy_armed got %b want 1", sts_busy); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL win_armed_tvalid got %b want 0", m_axis_tvalid); end
        pulse_trg();
        repeat (15) @(posedge aclk);
        @(negedge aclk);
        checks++;
        if (beat_q.size() != 8) begin
            errors++; $display("FAIL win_count got %0d want 8", beat_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++; if (last_q[i] !== (i == 7)) begin errors++; $display("FAIL win_last[%0d] got %b want %b", i, last_q[i], (i == 7)); end
                checks++; if (busy_q[i] !== (i != 7)) begin errors++; $display("FAIL win_busy[%0d] got %b want %b", i, busy_q[i], (i != 7)); end
                checks++; if (beat_q[i][31:16] !== beat_q[i][15:0] + 16'h0100) begin errors++; $display("FAIL win_pair[%0d] got %h want B=A+100", i, beat_q[i]); end
                if (i > 0) begin
                    checks++; if (beat_q[i][15:0] !== beat_q[i-1][15:0] + 16'd1) begin errors++; $display("FAIL win_ramp[%0d] got %h want %h", i, beat_q[i][15:0], beat_q[i-1][15:0] + 16'd1); end
                    checks++; if (cyc_q[i] != cyc_q[i-1] + 1) begin errors++; $display("FAIL win_gap[%0d] got cycle %0d want %0d", i, cyc_q[i], cyc_q[i-1] + 1); end
                end
            end
        end
        checks++; if (sts_drops !== 32'h0) begin errors++; $display("FAIL win_drops got %0d want 0", sts_drops); end
        checks++; if (sts_busy !== 1'b0) begin errors++; $display("FAIL win_busy_end got %b want 0", sts_busy); end
    endtask

    task automatic test_back_pressure();
        logic [31:0] held;
        int n;
        cfg_length = 32'd4;
        m_axis_tready = 1'b0;
        clear_q();
        arm_trig();
        n = 0;
        @(negedge aclk);
        while (!m_axis_tvalid && n < 20) begin
            @(negedge aclk);
            n++;
        end
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL bp_first_beat timeout got tvalid %b want 1", m_axis_tvalid); end
        held = m_axis_tdata;
        for (int i = 0; i < 2; i++) begin
            @(posedge aclk); @(negedge aclk);
            checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held) begin errors++; $display("FAIL bp_hold[%0d] got %b/%h want 1/%h", i, m_axis_tvalid, m_axis_tdata, held); end
        end
        @(posedge aclk); #2 m_axis_tready = 1'b1;
        @(negedge aclk);
        checks++; if (m_axis_tdata !== held) begin errors++; $display("FAIL bp_hold_final got %h want %h", m_axis_tdata, held); end
        checks++; if (sts_drops !== 32'd3) begin errors++; $display("FAIL bp_drops got %0d want 3", sts_drops); end
        checks++; if (sts_overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow got %b want 1", sts_overflow); end
        repeat (10) @(posedge aclk);
        @(negedge aclk);
        checks++;
        if (beat_q.size() != 4) begin
            errors++; $display("FAIL bp_count got %0d want 4", beat_q.size());
        end else begin
            checks++; if (beat_q[0] !== held) begin errors++; $display("FAIL bp_beat1 got %h want %h", beat_q[0], held); end
            checks++; if (beat_q[1][15:0] !== beat_q[0][15:0] + 16'd4) begin errors++; $display("FAIL bp_skip got %h want %h", beat_q[1][15:0], beat_q[0][15:0] + 16'd4); end
            checks++; if (beat_q[2][15:0] !== beat_q[1][15:0] + 16'd1) begin errors++; $display("FAIL bp_beat3 got %h want %h", beat_q[2][15:0], beat_q[1][15:0] + 16'd1); end
            checks++; if (beat_q[3][15:0] !== beat_q[2][15:0] + 16'd1) begin errors++; $display("FAIL bp_beat4 got %h want %h", beat_q[3][15:0], beat_q[2][15:0] + 16'd1); end
            checks++; if ({last_q[0], last_q[1], last_q[2], last_q[3]} !== 4'b0001) begin errors++; $display("FAIL bp_last got %b%b%b%b want 0001", last_q[0], last_q[1], last_q[2], last_q[3]); end
        end
        checks++; if (sts_drops !== 32'd3) begin errors++; $display("FAIL bp_drops_end got %0d want 3", sts_drops); end
        pulse_arm();
        @(negedge aclk);
        checks++; if (sts_drops !== 32'd0) begin errors++; $display("FAIL bp_rearm_drops got %0d want 0", sts_drops); end
        checks++; if (sts_overflow !== 1'b0) begin errors++; $display("FAIL bp_rearm_overflow got %b want 0", sts_overflow); end
        checks++; if (sts_busy !== 1'b1) begin errors++; $display("FAIL bp_rearm_busy got %b want 1", sts_busy); end
        pulse_stop();
        @(negedge aclk);
        checks++; if (sts_busy !== 1'b0) begin errors++; $display("FAIL bp_stop_busy got %b want 0", sts_busy); end
    endtask

    task automatic test_abort();
        logic [31:0] held;
        int n;
        int base;
        cfg_continuous = 1'b1;
        cfg_length = 32'd0;
        m_axis_tready = 1'b1;
        clear_q();
        arm_trig();
        n = 0;
        while (beat_q.size() < 5 && n < 30) begin
            @(negedge aclk);
            n++;
        end
        checks++; if (beat_q.size() < 5) begin errors++; $display("FAIL abort_stream timeout got %0d beats want 5", beat_q.size()); end
        @(posedge aclk); #2 m_axis_tready = 1'b0; stop = 1'b1;
        @(posedge aclk); #2 stop = 1'b0;
        @(negedge aclk);
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL abort_pending got %b want 1", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL abort_tlast got %b want 0", m_axis_tlast); end
        checks++; if (sts_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", sts_busy); end
        held = m_axis_tdata;
        base = beat_q.size();
        repeat (3) @(negedge aclk);
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held) begin errors++; $display("FAIL abort_hold got %b/%h want 1/%h", m_axis_tvalid, m_axis_tdata, held); end
        @(posedge aclk); #2 m_axis_tready = 1'b1;
        repeat (10) @(posedge aclk);
        @(negedge aclk);
        checks++;
        if (beat_q.size() != base + 1) begin
            errors++; $display("FAIL abort_count got %0d want %0d", beat_q.size(), base + 1);
        end else begin
            checks++; if (beat_q[base] !== held || last_q[base] !== 1'b0) begin errors++; $display("FAIL abort_final got %h/%b want %h/0", beat_q[base], last_q[base], held); end
        end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL abort_idle_tvalid got %b want 0", m_axis_tvalid); end
        cfg_continuous = 1'b0;
        cfg_length = 32'd4;
        @(posedge aclk); #2 arm = 1'b1; stop = 1'b1;
        @(posedge aclk); #2 arm = 1'b0; stop = 1'b0;
        @(negedge aclk);
        checks++; if (sts_busy !== 1'b0) begin errors++; $display("FAIL arm_stop_busy got %b want 0", sts_busy); end
        clear_q();
        pulse_trg();
        repeat (6) @(posedge aclk);
        @(negedge aclk);
        checks++; if (beat_q.size() != 0) begin errors++; $display("FAIL arm_stop_beats got %0d want 0", beat_q.size()); end
    endtask

    task automatic test_edge_cases();
        cfg_length = 32'd0;
        cfg_continuous = 1'b0;
        pulse_arm();
        @(negedge aclk);
        checks++; if (sts_busy !== 1'b0) begin errors++; $display("FAIL zero_len_busy got %b want 0", sts_busy); end
        cfg_length = 32'd8;
        m_axis_tready = 1'b0;
        arm_trig();
        repeat (4) @(posedge aclk);
        #3 aresetn = 1'b0;
        #1;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL arst_tvalid got %b want 0", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== 32'h0) begin errors++; $display("FAIL arst_tdata got %h want 0", m_axis_tdata); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL arst_tlast got %b want 0", m_axis_tlast); end
        checks++; if (sts_busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", sts_busy); end
        checks++; if (sts_overflow !== 1'b0) begin errors++; $display("FAIL arst_overflow got %b want 0", sts_overflow); end
        checks++; if (sts_drops !== 32'h0) begin errors++; $display("FAIL arst_drops got %0d want 0", sts_drops); end
        @(negedge aclk); #2 aresetn = 1'b1;
        m_axis_tready = 1'b1;
        clear_q();
        pulse_trg();
        repeat (10) @(posedge aclk);
        @(negedge aclk);
        checks++; if (beat_q.size() != 0) begin errors++; $display("FAIL post_reset_beats got %0d want 0", beat_q.size()); end
        checks++; if (sts_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", sts_busy); end
    endtask

    initial begin
        test_reset();
        test_format();
        test_window();
        test_back_pressure();
        test_abort();
        test_edge_cases();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
